// File: rtl/ddr3_wr_packer_if.sv
// Stream-in / MIG-app-out bundle for the DDR3 write packer.
// The master modport is the packer side; slave is the source plus MIG side.
interface ddr3_wr_packer_if #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned APP_DW = 128,
    parameter int unsigned ADDR_W = 32
);
    logic                  s_valid;
    logic [IN_W-1:0]       s_data;
    logic                  s_ready;
    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic [2:0]            app_cmd;
    logic                  app_cmd_en;
    logic [ADDR_W-1:0]     app_addr;
    logic [APP_DW-1:0]     app_wdf_data;
    logic [APP_DW/8-1:0]   app_wdf_mask;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;

    modport master (
        input  s_valid, s_data, app_rdy, app_wdf_rdy,
        output s_ready, app_cmd, app_cmd_en, app_addr,
               app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );

    modport slave (
        output s_valid, s_data, app_rdy, app_wdf_rdy,
        input  s_ready, app_cmd, app_cmd_en, app_addr,
               app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/ddr3_wr_packer.sv
// Packs a narrow word stream at incrementing byte addresses into masked
// APP_DW-bit MIG write lines, one app command per line.
module ddr3_wr_packer #(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned APP_DW  = 128,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WRAP_EN = 0
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_min,
    input  logic [ADDR_W-1:0] addr_max,
    input  logic              start,
    input  logic              flush,
    ddr3_wr_packer_if.master  bus,
    output logic              done,
    output logic [31:0]       line_cnt
);
    localparam int unsigned BPW    = IN_W / 8;
    localparam int unsigned LINE_B = APP_DW / 8;
    localparam int unsigned LANES  = APP_DW / IN_W;
    localparam int unsigned LSB    = $clog2(BPW);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_B - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BPW);

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_addr_min;
    logic [ADDR_W-1:0]   r_addr_max;
    logic [ADDR_W-1:0]   r_line_addr;
    logic [APP_DW-1:0]   r_data;
    logic [LINE_B-1:0]   r_mask;
    logic [31:0]         r_line_cnt;
    logic                r_end;

    logic                w_kill;
    logic                w_s_ready;
    logic                w_acc;
    logic                w_hs;
    logic                w_last;
    logic                w_at_end;
    logic                w_any;
    logic [LANE_W-1:0]   w_lane;
    logic [APP_DW-1:0]   w_data_nxt;
    logic [LINE_B-1:0]   w_mask_nxt;

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return a & ~OFF_MASK;
    endfunction

    // start and rst both abort whatever is in flight, including a pending strobe
    assign w_kill   = rst | start;
    assign w_lane   = LANE_W'((r_addr & OFF_MASK) >> LSB);
    assign w_last   = (w_lane == LANE_W'(LANES - 1));
    assign w_at_end = ((r_addr + STEP) == r_addr_max);
    assign w_any    = (r_mask != '1);

    // Lane write of the incoming word into the line buffer
    always_comb begin
        w_data_nxt = r_data;
        w_mask_nxt = r_mask;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (w_lane == LANE_W'(k)) begin
                w_data_nxt[k*IN_W +: IN_W] = bus.s_data;
                w_mask_nxt[k*BPW +: BPW]   = '0;
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (w_kill) r_state <= S_FILL;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_acc       = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            S_FILL: begin
                w_s_ready = ~w_kill;
                w_acc     = bus.s_valid & ~w_kill;
                if ((w_acc & (w_last | w_at_end)) | (flush & (w_any | w_acc)))
                    w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_hs = bus.app_rdy & bus.app_wdf_rdy & ~w_kill;
                if (w_hs)
                    w_state_nxt = (r_end && (WRAP_EN == 0)) ? S_DONE : S_FILL;
            end
            S_DONE: w_state_nxt = S_DONE;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Address, line buffer and counters
    always_ff @(posedge ui_clk) begin
        if (w_kill) begin
            r_addr      <= addr_min;
            r_addr_min  <= addr_min;
            r_addr_max  <= addr_max;
            r_line_addr <= line_of(addr_min);
            r_data      <= '0;
            r_mask      <= '1;
            r_line_cnt  <= '0;
            r_end       <= 1'b0;
        end else begin
            if (w_acc) begin
                r_data <= w_data_nxt;
                r_mask <= w_mask_nxt;
                r_addr <= r_addr + STEP;
                if (w_at_end) r_end <= 1'b1;
            end
            if (w_hs) begin
                r_data     <= '0;
                r_mask     <= '1;
                r_line_cnt <= r_line_cnt + 32'd1;
                r_end      <= 1'b0;
                if (!r_end) begin
                    r_line_addr <= line_of(r_addr);
                end else if (WRAP_EN != 0) begin
                    r_addr      <= r_addr_min;
                    r_line_addr <= line_of(r_addr_min);
                end
            end
        end
    end

    assign bus.s_ready      = w_s_ready;
    assign bus.app_cmd      = 3'b000;
    assign bus.app_cmd_en   = w_hs;
    assign bus.app_wdf_wren = w_hs;
    assign bus.app_wdf_end  = w_hs;
    assign bus.app_addr     = r_line_addr;
    assign bus.app_wdf_data = r_data;
    assign bus.app_wdf_mask = r_mask;
    assign done             = (r_state == S_DONE);
    assign line_cnt         = r_line_cnt;
endmodule
